// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM stage: load/store size codes, FSM states,
// byte-enable patterns and the alignment rule.
package mem_stage_pkg;

  localparam logic [1:0] LS_WORD = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_BYTE = 2'b10;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Code 2'b11 falls into the word rule.
  function automatic logic is_misaligned(input logic [1:0] sel, input logic [1:0] lsb);
    case (sel)
      LS_HALF: return lsb[0];
      LS_BYTE: return 1'b0;
      default: return (lsb != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/load_store_formatter.sv
// Combinational lane formatting: store replication and byte enables,
// load lane extraction with zero/sign extension.
module load_store_formatter
  import mem_stage_pkg::*;
#(
  parameter int NB_DATA           = 32,
  parameter int NB_LOAD_STORE_SEL = 2,
  parameter int NB_BYTE_ENB       = NB_DATA / 8
) (
  input  logic [NB_LOAD_STORE_SEL-1:0] i_sel,
  input  logic [1:0]                   i_addr_lsb,
  input  logic                         i_load_signed,
  input  logic [NB_DATA-1:0]           i_store_data,
  input  logic [NB_DATA-1:0]           i_load_word,
  output logic [NB_DATA-1:0]           o_store_data,
  output logic [NB_BYTE_ENB-1:0]       o_byte_enb,
  output logic [NB_DATA-1:0]           o_load_data
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;

  always_comb begin
    case (i_addr_lsb)
      2'd0:    load_byte = i_load_word[7:0];
      2'd1:    load_byte = i_load_word[15:8];
      2'd2:    load_byte = i_load_word[23:16];
      default: load_byte = i_load_word[31:24];
    endcase
    load_half = i_addr_lsb[1] ? i_load_word[31:16] : i_load_word[15:0];

    o_store_data = i_store_data;
    o_byte_enb   = BE_WORD;
    o_load_data  = i_load_word;
    case (i_sel)
      LS_HALF: begin
        o_store_data = {2{i_store_data[15:0]}};
        o_byte_enb   = i_addr_lsb[1] ? BE_HALF_HI : BE_HALF_LO;
        o_load_data  = {{(NB_DATA-16){i_load_signed & load_half[15]}}, load_half};
      end
      LS_BYTE: begin
        o_store_data = {4{i_store_data[7:0]}};
        o_byte_enb   = BE_BYTE0 << i_addr_lsb;
        o_load_data  = {{(NB_DATA-8){i_load_signed & load_byte[7]}}, load_byte};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// MEM stage of the 5-stage MIPS pipeline: data-memory access over req/ack,
// branch/jump redirect, MEM/WB latch and forwarding value for EX.
module memory_access_unit
  import mem_stage_pkg::*;
#(
  parameter int NB_ADDR           = 5,
  parameter int NB_DATA           = 2**NB_ADDR,
  parameter int NB_LOAD_STORE_SEL = 2,
  parameter int NB_BYTE_ENB       = NB_DATA / 8
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_enable,
  input  logic                         i_data_mem_wr_enb,
  input  logic                         i_data_mem_rd_enb,
  input  logic                         i_is_branch_instruction,
  input  logic                         i_is_jump_instruction,
  input  logic [NB_DATA-1:0]           i_jump_addr,
  input  logic [NB_DATA-1:0]           i_branch_addr,
  input  logic [NB_DATA-1:0]           i_alu_result,
  input  logic                         i_alu_zero,
  input  logic [NB_DATA-1:0]           i_rf_rt_data,
  input  logic [NB_LOAD_STORE_SEL-1:0] i_load_store_selector,
  input  logic                         i_load_signed,
  input  logic                         i_rf_wr_enb,
  input  logic                         i_rf_wr_data_src,
  input  logic [NB_ADDR-1:0]           i_rf_wr_addr,
  output logic                         o_dmem_req,
  output logic                         o_dmem_we,
  output logic [NB_DATA-1:0]           o_dmem_addr,
  output logic [NB_DATA-1:0]           o_dmem_wdata,
  output logic [NB_BYTE_ENB-1:0]       o_dmem_byte_enb,
  input  logic                         i_dmem_ack,
  input  logic [NB_DATA-1:0]           i_dmem_rdata,
  output logic                         o_stall,
  output logic                         o_pc_src,
  output logic [NB_DATA-1:0]           o_pc_target,
  output logic                         o_misaligned,
  output logic                         o_rf_wr_enb_ltchd,
  output logic                         o_rf_wr_data_src_ltchd,
  output logic [NB_ADDR-1:0]           o_rf_wr_addr_ltchd,
  output logic [NB_DATA-1:0]           o_alu_result_ltchd,
  output logic [NB_DATA-1:0]           o_mem_data_ltchd,
  output logic [NB_DATA-1:0]           o_wb_data
);

  state_e               state_q, state_d;
  logic [NB_DATA-1:0]   data_buf_q, data_buf_d;
  logic                 misaligned_q, misaligned_d;
  logic                 rf_wr_enb_q, rf_wr_enb_d;
  logic                 rf_wr_data_src_q, rf_wr_data_src_d;
  logic [NB_ADDR-1:0]   rf_wr_addr_q, rf_wr_addr_d;
  logic [NB_DATA-1:0]   alu_result_q, alu_result_d;
  logic [NB_DATA-1:0]   mem_data_q, mem_data_d;

  logic                 access, is_store, is_load, addr_misaligned;
  logic                 req, stall, latch_en, drop_access, redirect;
  logic [NB_DATA-1:0]   store_data, load_data;
  logic [NB_BYTE_ENB-1:0] store_be;

  assign access          = i_data_mem_rd_enb | i_data_mem_wr_enb;
  assign is_store        = i_data_mem_wr_enb;
  assign is_load         = i_data_mem_rd_enb & ~i_data_mem_wr_enb;
  assign addr_misaligned = is_misaligned(i_load_store_selector, i_alu_result[1:0]);

  load_store_formatter #(
    .NB_DATA           (NB_DATA),
    .NB_LOAD_STORE_SEL (NB_LOAD_STORE_SEL),
    .NB_BYTE_ENB       (NB_BYTE_ENB)
  ) u_formatter (
    .i_sel         (i_load_store_selector),
    .i_addr_lsb    (i_alu_result[1:0]),
    .i_load_signed (i_load_signed),
    .i_store_data  (i_rf_rt_data),
    .i_load_word   ((state_q == ST_HOLD) ? data_buf_q : i_dmem_rdata),
    .o_store_data  (store_data),
    .o_byte_enb    (store_be),
    .o_load_data   (load_data)
  );

  // Memory handshake: o_dmem_req stays high with address/data stable until the
  // cycle i_dmem_ack is seen; that cycle completes the access and carries rdata.
  // Stall drops on the completing cycle so upstream advances exactly once.
  always_comb begin
    state_d      = state_q;
    data_buf_d   = data_buf_q;
    misaligned_d = 1'b0;
    req          = 1'b0;
    stall        = 1'b0;
    latch_en     = 1'b0;
    drop_access  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_enable) begin
          if (access && addr_misaligned) begin
            latch_en     = 1'b1;
            drop_access  = 1'b1;
            misaligned_d = 1'b1;
          end else if (access) begin
            req = 1'b1;
            if (i_dmem_ack) begin
              latch_en = 1'b1;
            end else begin
              stall   = 1'b1;
              state_d = ST_WAIT;
            end
          end else begin
            latch_en = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        req   = 1'b1;
        stall = 1'b1;
        if (i_dmem_ack) begin
          data_buf_d = i_dmem_rdata;
          if (i_enable) begin
            latch_en = 1'b1;
            stall    = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        stall = 1'b1;
        if (i_enable) begin
          latch_en = 1'b1;
          stall    = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rf_wr_enb_d      = rf_wr_enb_q;
    rf_wr_data_src_d = rf_wr_data_src_q;
    rf_wr_addr_d     = rf_wr_addr_q;
    alu_result_d     = alu_result_q;
    mem_data_d       = mem_data_q;
    if (latch_en) begin
      rf_wr_enb_d      = i_rf_wr_enb & ~drop_access;
      rf_wr_data_src_d = i_rf_wr_data_src;
      rf_wr_addr_d     = i_rf_wr_addr;
      alu_result_d     = i_alu_result;
      mem_data_d       = (is_load && !drop_access) ? load_data : '0;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q          <= ST_IDLE;
      data_buf_q       <= '0;
      misaligned_q     <= 1'b0;
      rf_wr_enb_q      <= 1'b0;
      rf_wr_data_src_q <= 1'b0;
      rf_wr_addr_q     <= '0;
      alu_result_q     <= '0;
      mem_data_q       <= '0;
    end else begin
      state_q          <= state_d;
      data_buf_q       <= data_buf_d;
      misaligned_q     <= misaligned_d;
      rf_wr_enb_q      <= rf_wr_enb_d;
      rf_wr_data_src_q <= rf_wr_data_src_d;
      rf_wr_addr_q     <= rf_wr_addr_d;
      alu_result_q     <= alu_result_d;
      mem_data_q       <= mem_data_d;
    end
  end

  // Combinational outputs are masked by reset so an abandoned access drops at once.
  assign redirect        = i_is_jump_instruction | (i_is_branch_instruction & i_alu_zero);
  assign o_dmem_req      = req & i_reset;
  assign o_stall         = stall & i_reset;
  assign o_pc_src        = redirect & ~o_stall & i_reset;
  assign o_pc_target     = i_is_jump_instruction ? i_jump_addr : i_branch_addr;
  assign o_dmem_we       = is_store;
  assign o_dmem_addr     = {i_alu_result[NB_DATA-1:2], 2'b00};
  assign o_dmem_wdata    = store_data;
  assign o_dmem_byte_enb = is_store ? store_be : BE_NONE;

  assign o_misaligned           = misaligned_q;
  assign o_rf_wr_enb_ltchd      = rf_wr_enb_q;
  assign o_rf_wr_data_src_ltchd = rf_wr_data_src_q;
  assign o_rf_wr_addr_ltchd     = rf_wr_addr_q;
  assign o_alu_result_ltchd     = alu_result_q;
  assign o_mem_data_ltchd       = mem_data_q;
  assign o_wb_data              = rf_wr_data_src_q ? mem_data_q : alu_result_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed and randomized bench for memory_access_unit against an
// arithmetic reference model of lane formatting, alignment and redirect.
module tb_memory_access_unit;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_enable;
  logic        i_data_mem_wr_enb, i_data_mem_rd_enb;
  logic        i_is_branch_instruction, i_is_jump_instruction;
  logic [31:0] i_jump_addr, i_branch_addr, i_alu_result;
  logic        i_alu_zero;
  logic [31:0] i_rf_rt_data;
  logic [1:0]  i_load_store_selector;
  logic        i_load_signed, i_rf_wr_enb, i_rf_wr_data_src;
  logic [4:0]  i_rf_wr_addr;
  logic        o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic [3:0]  o_dmem_byte_enb;
  logic        i_dmem_ack;
  logic [31:0] i_dmem_rdata;
  logic        o_stall, o_pc_src;
  logic [31:0] o_pc_target;
  logic        o_misaligned, o_rf_wr_enb_ltchd, o_rf_wr_data_src_ltchd;
  logic [4:0]  o_rf_wr_addr_ltchd;
  logic [31:0] o_alu_result_ltchd, o_mem_data_ltchd, o_wb_data;

  int n_checks = 0;
  int n_fail   = 0;

  // current operation presented by the EX/MEM latch
  logic        op_wr, op_rd, op_br, op_jmp, op_zero, op_signed, op_rf_wr, op_src;
  logic [1:0]  op_sel;
  logic [4:0]  op_waddr;
  logic [31:0] op_addr, op_rt, op_rdata, op_baddr, op_jaddr;

  memory_access_unit dut (
    .i_clock                 (i_clock),
    .i_reset                 (i_reset),
    .i_enable                (i_enable),
    .i_data_mem_wr_enb       (i_data_mem_wr_enb),
    .i_data_mem_rd_enb       (i_data_mem_rd_enb),
    .i_is_branch_instruction (i_is_branch_instruction),
    .i_is_jump_instruction   (i_is_jump_instruction),
    .i_jump_addr             (i_jump_addr),
    .i_branch_addr           (i_branch_addr),
    .i_alu_result            (i_alu_result),
    .i_alu_zero              (i_alu_zero),
    .i_rf_rt_data            (i_rf_rt_data),
    .i_load_store_selector   (i_load_store_selector),
    .i_load_signed           (i_load_signed),
    .i_rf_wr_enb             (i_rf_wr_enb),
    .i_rf_wr_data_src        (i_rf_wr_data_src),
    .i_rf_wr_addr            (i_rf_wr_addr),
    .o_dmem_req              (o_dmem_req),
    .o_dmem_we               (o_dmem_we),
    .o_dmem_addr             (o_dmem_addr),
    .o_dmem_wdata            (o_dmem_wdata),
    .o_dmem_byte_enb         (o_dmem_byte_enb),
    .i_dmem_ack              (i_dmem_ack),
    .i_dmem_rdata            (i_dmem_rdata),
    .o_stall                 (o_stall),
    .o_pc_src                (o_pc_src),
    .o_pc_target             (o_pc_target),
    .o_misaligned            (o_misaligned),
    .o_rf_wr_enb_ltchd       (o_rf_wr_enb_ltchd),
    .o_rf_wr_data_src_ltchd  (o_rf_wr_data_src_ltchd),
    .o_rf_wr_addr_ltchd      (o_rf_wr_addr_ltchd),
    .o_alu_result_ltchd      (o_alu_result_ltchd),
    .o_mem_data_ltchd        (o_mem_data_ltchd),
    .o_wb_data               (o_wb_data)
  );

  // clock / reset
  always #5 i_clock = ~i_clock;

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic logic m_mis(input logic [1:0] sel, input logic [31:0] addr);
    if (sel == 2'b10) return 1'b0;
    if (sel == 2'b01) return (addr % 2) != 0;
    return (addr % 4) != 0;
  endfunction

  function automatic logic [31:0] m_be(input logic store, input logic [1:0] sel,
                                       input logic [31:0] addr);
    if (!store) return 32'd0;
    if (sel == 2'b10) return 32'd1 << (addr % 4);
    if (sel == 2'b01) return ((addr / 2) % 2 == 1) ? 32'd12 : 32'd3;
    return 32'd15;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sel, input logic [31:0] rt);
    if (sel == 2'b10) return (rt & 32'hFF) * 32'h0101_0101;
    if (sel == 2'b01) return (rt & 32'hFFFF) * 32'h0001_0001;
    return rt;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sel, input logic [31:0] addr,
                                         input logic sgn, input logic [31:0] word);
    logic [31:0] v;
    if (sel == 2'b10) begin
      v = (word >> (8 * (addr % 4))) & 32'hFF;
      if (sgn && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (sel == 2'b01) begin
      v = (word >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
      if (sgn && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  // driver
  task automatic clear_op();
    {op_wr, op_rd, op_br, op_jmp, op_zero, op_signed, op_rf_wr, op_src} = '0;
    op_sel = 2'b00; op_waddr = 5'd0;
    op_addr = 32'd0; op_rt = 32'd0; op_rdata = 32'd0; op_baddr = 32'd0; op_jaddr = 32'd0;
  endtask

  task automatic apply_op();
    i_enable                = 1'b1;
    i_data_mem_wr_enb       = op_wr;
    i_data_mem_rd_enb       = op_rd;
    i_is_branch_instruction = op_br;
    i_is_jump_instruction   = op_jmp;
    i_alu_zero              = op_zero;
    i_jump_addr             = op_jaddr;
    i_branch_addr           = op_baddr;
    i_alu_result            = op_addr;
    i_rf_rt_data            = op_rt;
    i_load_store_selector   = op_sel;
    i_load_signed           = op_signed;
    i_rf_wr_enb             = op_rf_wr;
    i_rf_wr_data_src        = op_src;
    i_rf_wr_addr            = op_waddr;
    i_dmem_ack              = 1'b0;
    i_dmem_rdata            = $urandom();
  endtask

  // Presents the current op, answers the request after ack_delay wait cycles,
  // then checks the MEM/WB latch one cycle after completion.
  task automatic run_op(input int ack_delay);
    logic acc, mis, redir;
    logic [31:0] ld;
    acc   = op_wr | op_rd;
    mis   = acc && m_mis(op_sel, op_addr);
    redir = op_jmp || (op_br && op_zero);
    ld    = m_load(op_sel, op_addr, op_signed, op_rdata);
    apply_op();
    if (acc && !mis) begin
      for (int k = 0; k <= ack_delay; k++) begin
        i_dmem_ack   = (k == ack_delay);
        i_dmem_rdata = (k == ack_delay) ? op_rdata : $urandom();
        #1;
        chk("dmem_req", o_dmem_req, 1);
        chk("dmem_we", o_dmem_we, op_wr);
        chk("dmem_addr", o_dmem_addr, op_addr & 32'hFFFF_FFFC);
        chk("dmem_be", o_dmem_byte_enb, m_be(op_wr, op_sel, op_addr));
        if (op_wr) chk("dmem_wdata", o_dmem_wdata, m_wdata(op_sel, op_rt));
        chk("stall", o_stall, k != ack_delay);
        chk("pc_src", o_pc_src, redir && (k == ack_delay));
        chk("pc_target", o_pc_target, op_jmp ? op_jaddr : op_baddr);
        tick();
      end
      i_dmem_ack = 1'b0;
    end else begin
      #1;
      chk("dmem_req_idle", o_dmem_req, 0);
      chk("stall_idle", o_stall, 0);
      chk("pc_src", o_pc_src, redir);
      chk("pc_target", o_pc_target, op_jmp ? op_jaddr : op_baddr);
      tick();
    end
    chk("misaligned", o_misaligned, mis);
    chk("wr_enb_l", o_rf_wr_enb_ltchd, op_rf_wr && !mis);
    chk("wr_src_l", o_rf_wr_data_src_ltchd, op_src);
    chk("wr_addr_l", o_rf_wr_addr_ltchd, op_waddr);
    chk("alu_l", o_alu_result_ltchd, op_addr);
    if (op_rd && !op_wr && !mis) begin
      chk("mem_data_l", o_mem_data_ltchd, ld);
      if (op_src) chk("wb_data_mem", o_wb_data, ld);
    end
    if (!op_src) chk("wb_data_alu", o_wb_data, op_addr);
  endtask

  initial begin
    i_reset = 1'b0;
    clear_op();
    apply_op();
    #23;
    chk("rst_req", o_dmem_req, 0);
    chk("rst_stall", o_stall, 0);
    chk("rst_pc_src", o_pc_src, 0);
    chk("rst_mis", o_misaligned, 0);
    chk("rst_wr_enb", o_rf_wr_enb_ltchd, 0);
    chk("rst_alu", o_alu_result_ltchd, 0);
    chk("rst_mem", o_mem_data_ltchd, 0);
    chk("rst_wb", o_wb_data, 0);
    @(negedge i_clock);
    i_reset = 1'b1;
    tick();

    // byte store, zero wait states
    clear_op();
    op_wr = 1; op_sel = 2'b10; op_addr = 32'h13; op_rt = 32'h1122_33AB;
    run_op(0);

    // signed half load, three wait cycles
    clear_op();
    op_rd = 1; op_sel = 2'b01; op_signed = 1; op_addr = 32'h22; op_rdata = 32'h8001_7FFF;
    op_rf_wr = 1; op_src = 1; op_waddr = 5'd9;
    run_op(3);

    // misaligned word load
    clear_op();
    op_rd = 1; op_sel = 2'b00; op_addr = 32'h06; op_rf_wr = 1; op_waddr = 5'd3;
    run_op(0);

    // jump wins over a taken branch, then untaken branch
    clear_op();
    op_br = 1; op_zero = 1; op_baddr = 32'h40; op_jmp = 1; op_jaddr = 32'h80;
    run_op(0);
    clear_op();
    op_br = 1; op_zero = 0; op_baddr = 32'h40; op_rf_wr = 1; op_waddr = 5'd7; op_addr = 32'h55;
    run_op(0);

    // enable dropped during WAIT: HOLD, then buffered data latches
    clear_op();
    op_rd = 1; op_sel = 2'b10; op_signed = 1; op_addr = 32'h101; op_rf_wr = 1; op_src = 1;
    op_waddr = 5'd5; op_br = 1; op_zero = 1; op_baddr = 32'h200;
    apply_op();
    #1;
    chk("hold_req0", o_dmem_req, 1);
    chk("hold_stall0", o_stall, 1);
    chk("hold_pc_gated", o_pc_src, 0);
    tick();
    i_enable = 1'b0;
    #1;
    chk("hold_stall1", o_stall, 1);
    tick();
    i_dmem_ack = 1'b1; i_dmem_rdata = 32'h0000_8000;
    #1;
    chk("hold_stall2", o_stall, 1);
    tick();
    i_dmem_ack = 1'b0; i_dmem_rdata = 32'hFFFF_FFFF;
    #1;
    chk("hold_req3", o_dmem_req, 0);
    chk("hold_stall3", o_stall, 1);
    chk("hold_alu_kept", o_alu_result_ltchd, 32'h55);
    tick();
    i_enable = 1'b1;
    #1;
    chk("hold_stall4", o_stall, 0);
    chk("hold_pc_src4", o_pc_src, 1);
    tick();
    chk("hold_mem_l", o_mem_data_ltchd, 32'hFFFF_FF80);
    chk("hold_wb", o_wb_data, 32'hFFFF_FF80);
    chk("hold_waddr", o_rf_wr_addr_ltchd, 5);

    // enable low in IDLE: no request, latches hold
    clear_op();
    op_wr = 1; op_addr = 32'h300; op_waddr = 5'd30;
    apply_op();
    i_enable = 1'b0;
    #1;
    chk("en0_req", o_dmem_req, 0);
    tick();
    chk("en0_alu_kept", o_alu_result_ltchd, 32'h101);
    chk("en0_waddr_kept", o_rf_wr_addr_ltchd, 5);

    // randomized operations
    for (int n = 0; n < 120; n++) begin
      clear_op();
      op_rd     = 1'($urandom_range(0, 1));
      op_wr     = 1'($urandom_range(0, 2) == 0);
      op_sel    = 2'($urandom_range(0, 3));
      op_signed = 1'($urandom_range(0, 1));
      op_addr   = $urandom();
      op_rt     = $urandom();
      op_rdata  = $urandom();
      op_rf_wr  = 1'($urandom_range(0, 1));
      op_src    = 1'($urandom_range(0, 1));
      op_waddr  = 5'($urandom_range(0, 31));
      op_br     = 1'($urandom_range(0, 1));
      op_zero   = 1'($urandom_range(0, 1));
      op_jmp    = 1'($urandom_range(0, 3) == 0);
      op_baddr  = $urandom();
      op_jaddr  = $urandom();
      run_op($urandom_range(0, 3));
    end

    // reset during WAIT abandons the access
    clear_op();
    op_rd = 1; op_addr = 32'h200; op_rf_wr = 1; op_src = 1; op_waddr = 5'd12;
    apply_op();
    tick();
    #1;
    chk("rstw_req_before", o_dmem_req, 1);
    i_reset = 1'b0;
    #1;
    chk("rstw_req", o_dmem_req, 0);
    chk("rstw_stall", o_stall, 0);
    chk("rstw_wr_enb", o_rf_wr_enb_ltchd, 0);
    chk("rstw_waddr", o_rf_wr_addr_ltchd, 0);
    chk("rstw_alu", o_alu_result_ltchd, 0);
    chk("rstw_mem", o_mem_data_ltchd, 0);
    clear_op();
    apply_op();
    @(negedge i_clock);
    i_reset = 1'b1;
    tick();
    chk("rstw_no_wb", o_rf_wr_enb_ltchd, 0);
    chk("rstw_req_after", o_dmem_req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_access_unit.md
Name: memory_access_unit

Overview:
- MEM stage of the 5-stage MIPS pipeline; consumes the EX/MEM latch outputs of the execution stage.
- Performs data-memory loads and stores over a req/ack memory interface, with byte/half/word lane formatting.
- Resolves branch/jump redirection to the fetch stage and drives the MEM/WB pipeline latch.
- Provides forwarding data back to EX and a stall to all upstream stages while a memory access is outstanding.

Parameters:
- NB_ADDR, 5, register-file address width.
- NB_DATA, 2**NB_ADDR, datapath width (32).
- NB_LOAD_STORE_SEL, 2, load/store size selector width.
- NB_BYTE_ENB, NB_DATA/8, byte-enable width (4).

Ports:
- i_clock  in  1  clock, rising edge.
- i_reset  in  1  reset, asynchronous, active-low (asserted at 0).
- i_enable  in  1  pipeline advance enable (debug halt when 0).
- i_data_mem_wr_enb  in  1  store instruction.
- i_data_mem_rd_enb  in  1  load instruction.
- i_is_branch_instruction  in  1  branch instruction (beq semantics).
- i_is_jump_instruction  in  1  jump instruction.
- i_jump_addr  in  NB_DATA  jump target.
- i_branch_addr  in  NB_DATA  branch target.
- i_alu_result  in  NB_DATA  effective address or ALU result.
- i_alu_zero  in  1  ALU zero flag.
- i_rf_rt_data  in  NB_DATA  store data.
- i_load_store_selector  in  NB_LOAD_STORE_SEL  00 word, 01 half, 10 byte, 11 treated as word.
- i_load_signed  in  1  sign-extend half/byte loads.
- i_rf_wr_enb  in  1  writeback enable.
- i_rf_wr_data_src  in  1  writeback source: 1 memory, 0 ALU.
- i_rf_wr_addr  in  NB_ADDR  destination register.
- o_dmem_req  out  1  memory request.
- o_dmem_we  out  1  1 write, 0 read.
- o_dmem_addr  out  NB_DATA  word-aligned address, {i_alu_result[31:2], 2'b00}.
- o_dmem_wdata  out  NB_DATA  lane-replicated store data.
- o_dmem_byte_enb  out  NB_BYTE_ENB  store byte enables.
- i_dmem_ack  in  1  access complete; i_dmem_rdata valid in the same cycle.
- i_dmem_rdata  in  NB_DATA  read word.
- o_stall  out  1  freezes upstream stages.
- o_pc_src  out  1  redirect fetch; also used as the IF/ID/EX flush.
- o_pc_target  out  NB_DATA  redirect address.
- o_misaligned  out  1  registered one-cycle pulse on a misaligned access.
- o_rf_wr_enb_ltchd  out  1  MEM/WB latched write enable.
- o_rf_wr_data_src_ltchd  out  1  MEM/WB latched writeback source.
- o_rf_wr_addr_ltchd  out  NB_ADDR  MEM/WB latched destination register.
- o_alu_result_ltchd  out  NB_DATA  MEM/WB latched ALU result.
- o_mem_data_ltchd  out  NB_DATA  MEM/WB latched formatted load data.
- o_wb_data  out  NB_DATA  forwarding value to EX: mem_data_ltchd when wr_data_src_ltchd is 1, else alu_result_ltchd.

Behaviour:
- Reset (i_reset=0, asynchronous): FSM goes to IDLE; all latches, o_misaligned and o_dmem_req go to 0; o_pc_src=0; o_stall=0. Reset mid-access abandons the request with no writeback.
- access = rd_enb | wr_enb.
- misalign:
  - word: addr[1:0]!=0.
  - half: addr[0]!=0.
  - byte: never misaligned.
- FSM states: IDLE, WAIT, HOLD.
  - IDLE, i_enable=1, access, aligned: o_dmem_req=1 combinationally. If i_dmem_ack=1 in the same cycle, the access completes in zero wait states and latches. Otherwise go to WAIT with o_stall=1.
  - WAIT: o_dmem_req=1 and o_stall=1. Upstream holds all inputs stable. On ack, rdata is captured into the data buffer; go to IDLE if i_enable=1 (latch update), else to HOLD.
  - HOLD: o_stall=1, no request. When i_enable=1, latch from the buffer and go to IDLE.
  - IDLE, misaligned access: no request. o_misaligned=1 next cycle. Latch with rf_wr_enb forced to 0; the store is suppressed.
  - IDLE, no access, i_enable=1: latch inputs with a 1-cycle latency.
  - i_enable=0 in IDLE: latches hold.
- Store formatting:
  - byte: wdata={4{rt[7:0]}}, be=4'b0001<<addr[1:0].
  - half: wdata={2{rt[15:0]}}, be = addr[1] ? 1100 : 0011.
  - word: wdata=rt, be=1111.
  - Reads drive be=0000.
- Load formatting:
  - Select the lane by addr[1:0] (byte) or addr[1] (half).
  - Zero- or sign-extend per i_load_signed.
  - Word loads pass through.
- Redirect is combinational from the inputs:
  - pc_src = jump | (branch & alu_zero).
  - target = jump ? jump_addr : branch_addr; jump has priority.
  - pc_src is gated to 0 while o_stall=1, so it is asserted exactly once per instruction.
- rd_enb and wr_enb both set: treated as a store.

Decomposition:
- Package mem_stage_pkg: load/store selector codes, FSM state encoding, byte-enable constants.
- Sub-module load_store_formatter: combinational store-lane and byte-enable generation, load extraction and extension.

Test Plan:
- Store byte, addr=0x0000_0013, rt=0x1122_33AB, ack in same cycle -> req=1, we=1, dmem_addr=0x10, wdata=0xABABABAB, be=1000, o_stall=0.
- Signed half load, addr=0x22, rdata=0x8001_7FFF, ack after 3 cycles -> o_stall=1 for 3 cycles; next cycle o_mem_data_ltchd=0xFFFF_8001 and o_wb_data=0xFFFF_8001 with wr_data_src=1.
- Word load at addr=0x06 -> no req; o_misaligned pulses 1 cycle; o_rf_wr_enb_ltchd=0.
- Branch with alu_zero=1, branch_addr=0x40, together with jump=1, jump_addr=0x80 -> o_pc_src=1, o_pc_target=0x80; branch alone with zero=0 -> o_pc_src=0.
- Load in WAIT with i_enable dropped before ack -> FSM enters HOLD, o_stall stays 1; buffered data latches when i_enable returns.
- Reset asserted during WAIT -> o_dmem_req=0 immediately (asynchronous), all latches 0, no writeback after release.
